// File: rtl/problem_5.sv
// 8x8 unsigned Wallace-tree multiplier with a registered 16-bit product.
// Define PROBLEM_5_PIPE_EN to register the two tree rows ahead of the final adder (latency 2 instead of 1).
module problem_5 (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  IN1,
    input  logic [7:0]  IN2,
    output logic [15:0] OUT
);

    // Half adder cell: {carry, sum}
    function automatic logic [1:0] ha(input logic a, input logic b);
        logic [1:0] r;
        r = {a & b, a ^ b};
        return r;
    endfunction

    // Full adder cell built from two half adders: {carry, sum}
    function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
        logic [1:0] h1;
        logic [1:0] h2;
        logic [1:0] r;
        h1 = ha(a, b);
        h2 = ha(h1[0], c);
        r  = {h1[1] | h2[1], h2[0]};
        return r;
    endfunction

    // Row-wise 3:2 compressor: returns {carry_row, sum_row}; bit-15 carry drops
    // out because the product never exceeds 16 bits.
    function automatic logic [31:0] csa(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] c);
        logic [15:0] s;
        logic [15:0] cr;
        logic [1:0]  r;
        s  = 16'h0000;
        cr = 16'h0000;
        for (int k = 0; k < 16; k++) begin
            r     = fa(a[k], b[k], c[k]);
            s[k]  = r[0];
            cr[k] = r[1];
        end
        return {cr[14:0], 1'b0, s};
    endfunction

    // Ripple carry-propagate adder; carry out of bit 15 is always zero.
    function automatic logic [15:0] cpa(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] s;
        logic [1:0]  r;
        logic        c;
        s    = 16'h0000;
        r    = ha(a[0], b[0]);
        s[0] = r[0];
        c    = r[1];
        for (int k = 1; k < 16; k++) begin
            r    = fa(a[k], b[k], c);
            s[k] = r[0];
            c    = r[1];
        end
        return s;
    endfunction

    logic [15:0] pp_s [8];
    logic [15:0] l1_s [6];
    logic [15:0] l2_s [4];
    logic [15:0] l3_s [3];
    logic [15:0] row_a_s;
    logic [15:0] row_b_s;
    logic [15:0] cpa_a_s;
    logic [15:0] cpa_b_s;
    logic [15:0] sum_s;

    // Partial-product AND array and the four reduction layers 8->6->4->3->2
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            pp_s[i] = 16'(IN1 & {8{IN2[i]}}) << i;
        end
        {l1_s[1], l1_s[0]} = csa(pp_s[0], pp_s[1], pp_s[2]);
        {l1_s[3], l1_s[2]} = csa(pp_s[3], pp_s[4], pp_s[5]);
        l1_s[4] = pp_s[6];
        l1_s[5] = pp_s[7];
        {l2_s[1], l2_s[0]} = csa(l1_s[0], l1_s[1], l1_s[2]);
        {l2_s[3], l2_s[2]} = csa(l1_s[3], l1_s[4], l1_s[5]);
        {l3_s[1], l3_s[0]} = csa(l2_s[0], l2_s[1], l2_s[2]);
        l3_s[2] = l2_s[3];
        {row_b_s, row_a_s} = csa(l3_s[0], l3_s[1], l3_s[2]);
    end

`ifdef PROBLEM_5_PIPE_EN
    logic [15:0] row_a_r;
    logic [15:0] row_b_r;

    // Pipeline stage holding the two tree rows ahead of the final adder
    always_ff @(posedge clk) begin
        if (rst) begin
            row_a_r <= 16'h0000;
            row_b_r <= 16'h0000;
        end else begin
            row_a_r <= row_a_s;
            row_b_r <= row_b_s;
        end
    end

    // Final adder fed from the registered rows
    always_comb begin
        cpa_a_s = row_a_r;
        cpa_b_s = row_b_r;
        sum_s   = cpa(cpa_a_s, cpa_b_s);
    end
`else
    // Final adder fed straight from the tree
    always_comb begin
        cpa_a_s = row_a_s;
        cpa_b_s = row_b_s;
        sum_s   = cpa(cpa_a_s, cpa_b_s);
    end
`endif

    // Product output register
    always_ff @(posedge clk) begin
        if (rst) begin
            OUT <= 16'h0000;
        end else begin
            OUT <= sum_s;
        end
    end

endmodule

// File: tb/tb_problem_5.sv
// Self-checking bench for problem_5: directed boundary/reset cases, random sweep and exhaustive sweep
// against a latency-delayed product model.
module tb_problem_5;

`ifdef PROBLEM_5_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in1;
    logic [7:0]  in2;
    logic [15:0] out;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q [$];
    logic [15:0] obs [8];
    logic [7:0]  b2b_a [3];
    logic [7:0]  b2b_b [3];

    problem_5 dut (
        .clk (clk),
        .rst (rst),
        .IN1 (in1),
        .IN2 (in2),
        .OUT (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    // One clock: apply inputs, advance the delay-line model, compare after the edge.
    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic r, input string tag);
        in1 = a;
        in2 = b;
        rst = r;
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            for (int i = 0; i < LAT; i++) exp_q.push_back(16'h0000);
        end else begin
            exp_q.push_back(16'(int'(a) * int'(b)));
            void'(exp_q.pop_front());
        end
        #1;
        check(tag, out, exp_q[0]);
    endtask

    initial begin
        b2b_a[0] = 8'd3;   b2b_b[0] = 8'd5;
        b2b_a[1] = 8'd10;  b2b_b[1] = 8'd20;
        b2b_a[2] = 8'd128; b2b_b[2] = 8'd2;

        step(8'd0, 8'd0, 1'b1, "reset");
        check("reset_zero", out, 16'h0000);
        step(8'd0, 8'd0, 1'b1, "reset");

        for (int i = 0; i < LAT; i++) step(8'd43, 8'd112, 1'b0, "hold_43x112");
        check("43x112", out, 16'd4816);
        for (int i = 0; i < LAT; i++) step(8'd255, 8'd255, 1'b0, "hold_255x255");
        check("255x255", out, 16'hFE01);
        for (int i = 0; i < LAT; i++) step(8'd0, 8'd200, 1'b0, "hold_0x200");
        check("0x200", out, 16'd0);
        for (int i = 0; i < LAT; i++) step(8'd1, 8'd77, 1'b0, "hold_1x77");
        check("1x77", out, 16'd77);

        for (int n = 0; n < 3 + LAT; n++) begin
            if (n < 3) step(b2b_a[n], b2b_b[n], 1'b0, "b2b");
            else       step(8'd0, 8'd0, 1'b0, "b2b");
            obs[n] = out;
        end
        check("b2b_15", obs[LAT - 1], 16'd15);
        check("b2b_200", obs[LAT], 16'd200);
        check("b2b_256", obs[LAT + 1], 16'd256);

        // Reset with a product in flight: nothing from before reset may surface
        step(8'd255, 8'd255, 1'b0, "pre_reset");
        for (int i = 0; i < 2; i++) begin
            step(8'd100, 8'd100, 1'b1, "mid_reset");
            check("mid_reset_zero", out, 16'h0000);
        end
        for (int k = 1; k <= LAT; k++) begin
            step(8'd100, 8'd100, 1'b0, "post_reset");
            if (k < LAT) check("post_reset_zero", out, 16'h0000);
            else         check("post_reset_10000", out, 16'd10000);
        end

        for (int i = 0; i < 10000; i++) begin
            step(8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)), 1'b0, "random");
        end

        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                step(8'(a), 8'(b), 1'b0, "exhaustive");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/problem_5.md
PROBLEM_5 -- requirements
Module: problem_5

Interface
No parameters; operand width fixed at 8 bits.
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-004 IN1  input  8  unsigned multiplicand.
REQ-005 IN2  input  8  unsigned multiplier.
REQ-006 OUT  output 16  unsigned product IN1*IN2, registered.

Function
REQ-007 The block SHALL compute the full 16-bit unsigned product; no truncation, no overflow possible (max 255*255 = 65025).
REQ-008 Partial products SHALL be formed as an 8x8 AND array: pp[i][j] = IN1[j] & IN2[i], weight 2^(i+j).
REQ-009 Partial products SHALL be reduced by a Wallace tree of full adders (3:2) and half adders (2:2), in four layers: 8->6->4->3->2 rows.
REQ-010 Each layer SHALL group rows in threes; leftover rows pass through unchanged to the next layer.
REQ-011 The two final rows SHALL be summed by a 16-bit carry-propagate adder; the carry out of bit 15 is always 0 and is discarded.
REQ-012 The datapath SHALL NOT use the * operator; full-adder and half-adder cells are explicit.
REQ-013 Without PROBLEM_5_PIPE_EN: OUT SHALL update on every rising clk edge with rst low to the product of the IN1/IN2 values present at that edge (latency 1 cycle).
REQ-014 With PROBLEM_5_PIPE_EN: latency SHALL be 2 cycles; a new operand pair is accepted every cycle (throughput 1/cycle).
REQ-015 OUT SHALL change only on rising clk edges and never glitch combinationally.
REQ-016 Boundary: a zero operand SHALL give OUT = 0; 255*255 SHALL give 16'hFE01; 1*x SHALL give x zero-extended.

Reset
REQ-017 While rst is high at a rising edge, OUT and every internal pipeline register SHALL load 0.
REQ-018 Reset asserted mid-operation SHALL discard all in-flight products; no pre-reset product may appear on OUT afterwards.
REQ-019 After rst deasserts, the first valid product SHALL appear after the stated latency; until then OUT SHALL read 0.

Configuration
REQ-020 Macro PROBLEM_5_PIPE_EN SHALL control an extra pipeline register stage between the 2-row Wallace tree output and the final carry-propagate adder.
REQ-021 When PROBLEM_5_PIPE_EN is defined, latency SHALL be 2 cycles, with both rows (2x16 bits) registered and reset to 0.
REQ-022 When PROBLEM_5_PIPE_EN is undefined, the tree and adder SHALL be purely combinational into the OUT register, with latency 1 cycle.
REQ-023 Both builds SHALL produce identical result sequences, offset only by latency.

Verification
REQ-024 IN1=43, IN2=112 held -> OUT=4816 (16'h12D0) after the latency.
REQ-025 IN1=255, IN2=255 -> OUT=65025; IN1=0, IN2=200 -> OUT=0; IN1=1, IN2=77 -> OUT=77.
REQ-026 Back-to-back pairs (3,5),(10,20),(128,2) on consecutive cycles -> OUT yields 15, 200, 256 on consecutive cycles at the build's latency.
REQ-027 rst high for 2 cycles while IN1=100, IN2=100 -> OUT=0 throughout reset; OUT=10000 appears exactly the latency after rst falls.
REQ-028 Random sweep of at least 10000 pairs, plus all 65536 pairs exhaustively -> OUT matches IN1*IN2 delayed by the latency, in both macro builds.
